sha_block_loader: RTL and testbench

//  Front end of the super-pipelined SHA-256 core. Accepts message words one per cycle over a

---
 rtl/sha_pkg.sv | 28 ++
 rtl/sha_block_loader.sv | 105 ++++++++++
 tb/tb_sha_block_loader.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sha_pkg.sv
// Shared SHA-256 types and constants for the round pipeline front end.
package sha_pkg;

   localparam int SHA_WORDS  = 16;
   localparam int SHA_WORD_W = 32;
   localparam int SHA_CNT_W  = $clog2(SHA_WORDS);

   // Working variables a..h, a in the most significant position.
   typedef struct packed {
      logic [SHA_WORD_W-1:0] a;
      logic [SHA_WORD_W-1:0] b;
      logic [SHA_WORD_W-1:0] c;
      logic [SHA_WORD_W-1:0] d;
      logic [SHA_WORD_W-1:0] e;
      logic [SHA_WORD_W-1:0] f;
      logic [SHA_WORD_W-1:0] g;
      logic [SHA_WORD_W-1:0] h;
   } HashState;

   // One message block; element 0 is the first word received.
   typedef logic [SHA_WORDS-1:0][SHA_WORD_W-1:0] sha_block_t;

   localparam HashState SHA256_IV = '{
      a: 32'h6a09e667, b: 32'hbb67ae85, c: 32'h3c6ef372, d: 32'ha54ff53a,
      e: 32'h510e527f, f: 32'h9b05688c, g: 32'h1f83d9ab, h: 32'h5be0cd19
   };

endpackage

// File: rtl/sha_block_loader.sv
// Message word loader: assembles 16-word blocks and issues each one as a
// single-cycle beat. An assembly buffer and an output register let the next
// block be collected while the current one waits out a downstream hold.
module sha_block_loader
   import sha_pkg::*;
(
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [SHA_WORD_W-1:0]                  word_i,
   input  logic                                   word_valid_i,
   output logic                                   word_ready_o,
   input  logic                                   first_i,
   input  HashState                               midstate_i,
   input  logic                                   abort_i,
   input  logic                                   hold_i,
   output HashState                               state_o,
   output logic [SHA_WORDS-1:0][SHA_WORD_W-1:0]   W_o,
   output logic                                   valid_o,
   output logic                                   newblock_o
);

   logic [SHA_CNT_W-1:0] r_cnt;
   logic                 r_asm_full;
   logic                 r_out_full;
   sha_block_t           r_asm;
   HashState             r_asm_state;
   logic                 r_asm_first;
   sha_block_t           r_out_w;
   HashState             r_out_state;
   logic                 r_out_first;

   logic w_out_free;
   logic w_ready;
   logic w_accept;
   logic w_transfer;
   logic w_issue;
   logic w_last_word;

   // Output slot can take a block if empty or if its block leaves this cycle.
   // Ready is forced low while reset is asserted, not just after the edge.
   always_comb begin
      w_out_free  = !r_out_full || !hold_i;
      w_ready     = rst && (!r_asm_full || w_out_free);
      w_accept    = word_valid_i && w_ready && !abort_i;
      w_transfer  = r_asm_full && w_out_free;
      w_issue     = r_out_full && !hold_i;
      w_last_word = (r_cnt == SHA_CNT_W'(SHA_WORDS - 1));
   end

   assign word_ready_o = w_ready;
   assign valid_o      = w_issue;
   assign W_o          = r_out_w;
   assign state_o      = r_out_state;
   assign newblock_o   = r_out_first;

   // Word counter and buffer occupancy flags. An accept while asm_full can
   // only happen on a transfer edge, where cnt has already wrapped to 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt      <= '0;
         r_asm_full <= 1'b0;
         r_out_full <= 1'b0;
      end else begin
         if (abort_i && !r_asm_full)
            r_cnt <= '0;
         else if (w_accept)
            r_cnt <= r_cnt + 1'b1;

         if (w_accept && w_last_word)
            r_asm_full <= 1'b1;
         else if (w_transfer)
            r_asm_full <= 1'b0;

         if (w_transfer)
            r_out_full <= 1'b1;
         else if (w_issue)
            r_out_full <= 1'b0;
      end
   end

   // Assembly data: contents are only meaningful once asm_full is set, so no reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_asm[r_cnt] <= word_i;
         if (r_cnt == '0) begin
            r_asm_first <= first_i;
            r_asm_state <= first_i ? SHA256_IV : midstate_i;
         end
      end
   end

   // Output register: loads on transfer, otherwise stays stable through holds.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_w     <= '0;
         r_out_state <= '0;
         r_out_first <= 1'b0;
      end else if (w_transfer) begin
         r_out_w     <= r_asm;
         r_out_state <= r_asm_state;
         r_out_first <= r_asm_first;
      end
   end

endmodule

// File: tb/tb_sha_block_loader.sv
// Directed and randomized bench for sha_block_loader with a block scoreboard.
`timescale 1ns/1ps
module tb_sha_block_loader;
   import sha_pkg::*;

   typedef struct {
      sha_block_t W;
      HashState   s;
      logic       f;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [31:0] word_i = '0;
   logic       word_valid_i = 1'b0;
   logic       word_ready_o;
   logic       first_i = 1'b0;
   HashState   midstate_i = '0;
   logic       abort_i = 1'b0;
   logic       hold_i = 1'b0;
   HashState   state_o;
   sha_block_t W_o;
   logic       valid_o;
   logic       newblock_o;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int beats = 0;
   int acc_cyc;
   int mcnt  = 0;
   sha_block_t mW;
   HashState   mstate;
   logic       mfirst;
   exp_t       q[$];
   int         vcyc[$];
   exp_t       me;

   sha_block_loader dut (
      .clk(clk), .rst(rst), .word_i(word_i), .word_valid_i(word_valid_i),
      .word_ready_o(word_ready_o), .first_i(first_i), .midstate_i(midstate_i),
      .abort_i(abort_i), .hold_i(hold_i), .state_o(state_o), .W_o(W_o),
      .valid_o(valid_o), .newblock_o(newblock_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer: every issued beat must match the oldest expected block.
   always @(negedge clk) begin
      if (rst && valid_o) begin
         beats++;
         vcyc.push_back(cyc);
         if (q.size() == 0) chk("unexpected_beat", 1, 0);
         else begin
            me = q.pop_front();
            chk("W", W_o, me.W);
            chk("state", state_o, me.s);
            chk("newblock", newblock_o, me.f);
         end
      end
   end

   function automatic HashState rnd_state();
      HashState s;
      s = '{a:$urandom, b:$urandom, c:$urandom, d:$urandom,
            e:$urandom, f:$urandom, g:$urandom, h:$urandom};
      return s;
   endfunction

   // Present one word, wait (bounded) for ready, and record the accept in the model.
   task automatic send_word(input logic [31:0] w, input logic f, input HashState m,
                            output int stalls);
      word_i = w; first_i = f; midstate_i = m; word_valid_i = 1'b1; stalls = 0;
      @(negedge clk);
      while (!word_ready_o && stalls < 200) begin
         stalls++;
         @(negedge clk);
      end
      if (!word_ready_o) chk("ready_timeout", 0, 1);
      @(posedge clk); #1;
      acc_cyc = cyc;
      word_valid_i = 1'b0;
      if (mcnt == 0) begin
         mfirst = f;
         mstate = f ? SHA256_IV : m;
      end
      mW[mcnt] = w;
      mcnt++;
      if (mcnt == SHA_WORDS) begin
         q.push_back('{W: mW, s: mstate, f: mfirst});
         mcnt = 0;
      end
   endtask

   initial begin
      int st, sum, b0, e;
      HashState mid;
      mid = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ready", word_ready_o, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_W", W_o, 0);
      chk("rst_state", state_o, 0);
      chk("rst_newblock", newblock_o, 0);
      @(posedge clk); #1; rst = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", word_ready_o, 1);
      @(posedge clk); #1;

      // 1: single block, latency and single-cycle beat
      vcyc.delete(); b0 = beats;
      for (int k = 0; k < 16; k++) send_word(k, 1'b1, mid, st);
      e = acc_cyc;
      repeat (6) @(negedge clk);
      chk("t1_beats", beats - b0, 1);
      if (vcyc.size() > 0) chk("t1_latency", vcyc[0] - e, 1);
      @(posedge clk); #1;

      // 2: two blocks back to back, chained midstate
      vcyc.delete(); sum = 0;
      mid = rnd_state(); mid.a = 32'hDEADBEEF;
      for (int k = 0; k < 32; k++) begin
         send_word(32'h1000 + k, (k < 16), mid, st);
         sum += st;
      end
      repeat (20) @(negedge clk);
      chk("t2_no_stall", sum, 0);
      chk("t2_beats", vcyc.size(), 2);
      if (vcyc.size() == 2) chk("t2_spacing", vcyc[1] - vcyc[0], 16);
      @(posedge clk); #1;

      // 3: hold with both buffers filling, then release
      hold_i = 1'b1; sum = 0; b0 = beats;
      mid = rnd_state();
      for (int k = 0; k < 32; k++) begin
         send_word(32'h3000 + k, (k == 0), mid, st);
         sum += st;
      end
      chk("t3_fill_no_stall", sum, 0);
      @(negedge clk);
      chk("t3_ready_low", word_ready_o, 0);
      chk("t3_valid_low", valid_o, 0);
      if (q.size() > 0) chk("t3_W_held", W_o, q[0].W);
      word_i = 32'h3020; first_i = 1'b1; word_valid_i = 1'b1;
      repeat (3) @(negedge clk);
      chk("t3_ready_held", word_ready_o, 0);
      chk("t3_beats_held", beats - b0, 0);
      @(posedge clk); #1;
      hold_i = 1'b0; vcyc.delete();
      send_word(32'h3020, 1'b1, mid, st);
      chk("t3_ready_returns", st, 0);
      for (int k = 33; k < 48; k++) send_word(32'h3000 + k, 1'b0, mid, st);
      repeat (20) @(negedge clk);
      chk("t3_beats", vcyc.size(), 3);
      if (vcyc.size() >= 2) chk("t3_same_edge", vcyc[1] - vcyc[0], 1);
      @(posedge clk); #1;

      // 4: abort a partial block
      b0 = beats;
      for (int k = 0; k < 7; k++) send_word(32'h200 + k, 1'b1, mid, st);
      word_i = 32'h207; word_valid_i = 1'b1; abort_i = 1'b1;
      @(posedge clk); #1;
      abort_i = 1'b0; word_valid_i = 1'b0; mcnt = 0;
      mid = rnd_state();
      for (int k = 0; k < 16; k++) send_word(32'h100 + k, 1'b0, mid, st);
      repeat (6) @(negedge clk);
      chk("t4_beats", beats - b0, 1);
      @(posedge clk); #1;

      // 5: reset mid-block with a held block in the output register
      hold_i = 1'b1;
      for (int k = 0; k < 25; k++) send_word(32'h500 + k, 1'b1, mid, st);
      rst = 1'b0; hold_i = 1'b0;
      #1;
      chk("t5_valid", valid_o, 0);
      chk("t5_ready", word_ready_o, 0);
      chk("t5_W", W_o, 0);
      chk("t5_newblock", newblock_o, 0);
      q.delete(); mcnt = 0;
      repeat (2) @(posedge clk);
      #1; rst = 1'b1;
      b0 = beats; mid = rnd_state();
      for (int k = 0; k < 16; k++) send_word(32'h600 + k, 1'b0, mid, st);
      repeat (6) @(negedge clk);
      chk("t5_fresh_beats", beats - b0, 1);
      @(posedge clk); #1;

      // 6: random gaps and short holds over 50 blocks
      b0 = beats;
      for (int b = 0; b < 50; b++) begin
         logic f;
         f = ($urandom_range(0, 3) == 0);
         mid = rnd_state();
         for (int k = 0; k < 16; k++) begin
            while ($urandom_range(0, 99) < 30) begin
               word_valid_i = 1'b0;
               hold_i = $urandom_range(0, 1);
               @(posedge clk); #1;
               hold_i = 1'b0;
            end
            send_word($urandom, f, rnd_state(), st);
            if (k == 0) begin
               // model latched state from the word-0 midstate just sent
            end
         end
      end
      for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
      chk("t6_beats", beats - b0, 50);
      chk("drain", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
